branch_predict_resolver: RTL and testbench

// - Consumer of the CMP condition: predicts conditional branches in D and resolves them in E.
// - The CMP block has been moved to E; the delay slot sits in D, and F holds one speculative instruction.
// - A 2-bit saturating BHT (branch history table) drives the D-stage fetch redirect.
// - E-stage resolution raises a mispredict redirect and flushes F. Hit/miss statistics are kept.

---
 rtl/branch_predict_resolver_pkg.sv | 30 +++
 rtl/branch_predict_resolver_bht_table.sv | 38 +++
 rtl/branch_predict_resolver.sv | 94 +++++++++
 tb/tb_branch_predict_resolver.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/branch_predict_resolver_pkg.sv
// Shared definitions for the branch predictor / resolver slice.
//   bht_state_e : 2-bit saturating counter encodings (MSB = predict taken)
//   bht_step    : saturating +1/-1 step of a counter
//   bht_idx     : word-aligned PC to BHT index (pc[idx_bits+1:2])
package branch_predict_resolver_pkg;

   typedef enum logic [1:0] {
      BHT_SNT = 2'b00,
      BHT_WNT = 2'b01,
      BHT_WT  = 2'b10,
      BHT_ST  = 2'b11
   } bht_state_e;

   function automatic logic [1:0] bht_step(input logic [1:0] cur, input logic taken);
      logic [1:0] nxt;
      nxt = cur;
      if (taken) begin
         if (cur != BHT_ST)  nxt = cur + 2'd1;
      end else begin
         if (cur != BHT_SNT) nxt = cur - 2'd1;
      end
      return nxt;
   endfunction

   // Returned full width; callers cast down to their index width.
   function automatic logic [31:0] bht_idx(input logic [31:0] pc, input int unsigned idx_bits);
      return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
   endfunction

endpackage

// File: rtl/branch_predict_resolver_bht_table.sv
// Branch history table: array of 2-bit counters.
//   clk, rst_n     : clock, asynchronous active-low reset (all entries := INIT_STATE)
//   i_rd_idx       : D-stage lookup index
//   o_rd_data      : D-stage counter (pre-edge value, no bypass)
//   i_wr_idx       : E-stage index; o_wr_cur returns its current counter
//   i_wr_en        : write i_wr_data into entry i_wr_idx at the rising edge
module branch_predict_resolver_bht_table #(
   parameter int unsigned IDX_BITS   = 6,
   parameter logic [1:0]  INIT_STATE = 2'b01
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IDX_BITS-1:0] i_rd_idx,
   output logic [1:0]          o_rd_data,
   input  logic [IDX_BITS-1:0] i_wr_idx,
   output logic [1:0]          o_wr_cur,
   input  logic                i_wr_en,
   input  logic [1:0]          i_wr_data
);

   localparam int unsigned ENTRIES = 2 ** IDX_BITS;

   logic [1:0] r_bht [ENTRIES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_bht[i] <= INIT_STATE;
         end
      end else if (i_wr_en) begin
         r_bht[i_wr_idx] <= i_wr_data;
      end
   end

   assign o_rd_data = r_bht[i_rd_idx];
   assign o_wr_cur  = r_bht[i_wr_idx];

endmodule

// File: rtl/branch_predict_resolver.sv
// Predicts conditional branches in D from a 2-bit BHT and resolves them in E
// using the CMP result; keeps resolved/mispredicted statistics.
//   clk, reset                      : clock, asynchronous active-low reset
//   stall                           : F/D frozen (suppresses the D redirect only)
//   d_valid/d_is_branch/d_pc/d_target : D-stage instruction
//   d_pred_taken, d_redirect, d_redirect_pc : D prediction and fetch redirect
//   e_valid/e_is_branch/e_pc/e_target/e_pred_taken, cmp_result : E branch
//   e_redirect, e_redirect_pc, flush_f : mispredict recovery
//   br_count, miss_count            : wrapping statistics
module branch_predict_resolver
   import branch_predict_resolver_pkg::*;
#(
   parameter int unsigned IDX_BITS   = 6,
   parameter logic [1:0]  INIT_STATE = 2'b01
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        d_valid,
   input  logic        d_is_branch,
   input  logic [31:0] d_pc,
   input  logic [31:0] d_target,
   output logic        d_pred_taken,
   output logic        d_redirect,
   output logic [31:0] d_redirect_pc,
   input  logic        e_valid,
   input  logic        e_is_branch,
   input  logic [31:0] e_pc,
   input  logic [31:0] e_target,
   input  logic        e_pred_taken,
   input  logic        cmp_result,
   output logic        e_redirect,
   output logic [31:0] e_redirect_pc,
   output logic        flush_f,
   output logic [31:0] br_count,
   output logic [31:0] miss_count
);

   logic [IDX_BITS-1:0] w_d_idx;
   logic [IDX_BITS-1:0] w_e_idx;
   logic [1:0]          w_d_cnt;
   logic [1:0]          w_e_cnt;
   logic [1:0]          w_e_next;
   logic                w_e_upd;
   logic                w_mispredict;
   logic [31:0]         r_br_count;
   logic [31:0]         r_miss_count;

   assign w_d_idx = IDX_BITS'(bht_idx(d_pc, IDX_BITS));
   assign w_e_idx = IDX_BITS'(bht_idx(e_pc, IDX_BITS));

   // Updates are not gated by stall: a stalled branch reaches E as a bubble.
   assign w_e_upd  = e_valid & e_is_branch;
   assign w_e_next = bht_step(w_e_cnt, cmp_result);

   branch_predict_resolver_bht_table #(
      .IDX_BITS   (IDX_BITS),
      .INIT_STATE (INIT_STATE)
   ) u_bht (
      .clk       (clk),
      .rst_n     (reset),
      .i_rd_idx  (w_d_idx),
      .o_rd_data (w_d_cnt),
      .i_wr_idx  (w_e_idx),
      .o_wr_cur  (w_e_cnt),
      .i_wr_en   (w_e_upd),
      .i_wr_data (w_e_next)
   );

   // Redirects are held low while reset is asserted.
   assign w_mispredict  = reset & w_e_upd & (cmp_result != e_pred_taken);
   assign e_redirect    = w_mispredict;
   assign flush_f       = w_mispredict;
   assign e_redirect_pc = cmp_result ? e_target : (e_pc + 32'd8);

   assign d_pred_taken  = w_d_cnt[1] & d_valid & d_is_branch;
   // An E mispredict means D holds a wrong-path instruction, so it loses.
   assign d_redirect    = reset & d_pred_taken & ~stall & ~w_mispredict;
   assign d_redirect_pc = d_target;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_br_count   <= '0;
         r_miss_count <= '0;
      end else if (w_e_upd) begin
         r_br_count <= r_br_count + 32'd1;
         if (w_mispredict) r_miss_count <= r_miss_count + 32'd1;
      end
   end

   assign br_count   = r_br_count;
   assign miss_count = r_miss_count;

endmodule

// File: tb/tb_branch_predict_resolver.sv
module tb_branch_predict_resolver;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        d_valid = 1'b0, d_is_branch = 1'b0;
   logic [31:0] d_pc = '0, d_target = '0;
   logic        d_pred_taken, d_redirect;
   logic [31:0] d_redirect_pc;
   logic        e_valid = 1'b0, e_is_branch = 1'b0;
   logic [31:0] e_pc = '0, e_target = '0;
   logic        e_pred_taken = 1'b0, cmp_result = 1'b0;
   logic        e_redirect, flush_f;
   logic [31:0] e_redirect_pc, br_count, miss_count;

   always #5 clk = ~clk;

   branch_predict_resolver #(.IDX_BITS(6), .INIT_STATE(2'b01)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .d_valid(d_valid), .d_is_branch(d_is_branch), .d_pc(d_pc), .d_target(d_target),
      .d_pred_taken(d_pred_taken), .d_redirect(d_redirect), .d_redirect_pc(d_redirect_pc),
      .e_valid(e_valid), .e_is_branch(e_is_branch), .e_pc(e_pc), .e_target(e_target),
      .e_pred_taken(e_pred_taken), .cmp_result(cmp_result),
      .e_redirect(e_redirect), .e_redirect_pc(e_redirect_pc), .flush_f(flush_f),
      .br_count(br_count), .miss_count(miss_count)
   );

   // Reference model: one saturating integer counter per index, plus stats.
   int unsigned mdl_cnt [64];
   int unsigned mdl_br, mdl_miss;

   typedef struct {
      logic        pred;
      logic        d_redir;
      logic [31:0] d_rpc;
      logic        e_redir;
      logic [31:0] e_rpc;
      logic        flush;
      logic [31:0] br;
      logic [31:0] miss;
   } exp_t;

   exp_t sbq[$];
   int unsigned total = 0;
   int unsigned bad   = 0;

   function automatic int unsigned idx_of(input logic [31:0] pc);
      return (pc / 4) % 64;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) mdl_cnt[i] = 1;
      mdl_br   = 0;
      mdl_miss = 0;
   endtask

   // Apply one cycle of inputs at the falling edge, queue the expected
   // response for that cycle, then advance the model past the rising edge.
   task automatic step(input logic rst, input logic stl,
                       input logic dv, input logic dbr, input logic [31:0] dpc, input logic [31:0] dtgt,
                       input logic ev, input logic ebr, input logic [31:0] epc, input logic [31:0] etgt,
                       input logic epred, input logic cmpr);
      exp_t e;
      logic mis;
      @(negedge clk);
      reset = rst; stall = stl;
      d_valid = dv; d_is_branch = dbr; d_pc = dpc; d_target = dtgt;
      e_valid = ev; e_is_branch = ebr; e_pc = epc; e_target = etgt;
      e_pred_taken = epred; cmp_result = cmpr;
      if (!rst) model_reset();
      mis       = rst && ev && ebr && (cmpr != epred);
      e.pred    = (mdl_cnt[idx_of(dpc)] >= 2) && dv && dbr;
      e.d_redir = rst && e.pred && !stl && !mis;
      e.d_rpc   = dtgt;
      e.e_redir = mis;
      e.flush   = mis;
      e.e_rpc   = cmpr ? etgt : epc + 32'd8;
      e.br      = mdl_br;
      e.miss    = mdl_miss;
      sbq.push_back(e);
      if (rst && ev && ebr) begin
         if (cmpr) begin
            if (mdl_cnt[idx_of(epc)] < 3) mdl_cnt[idx_of(epc)]++;
         end else begin
            if (mdl_cnt[idx_of(epc)] > 0) mdl_cnt[idx_of(epc)]--;
         end
         mdl_br++;
         if (mis) mdl_miss++;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
      end
   endtask

   // Monitor: outputs are valid every cycle; sample 2ns after the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("d_pred_taken",  {31'd0, d_pred_taken}, {31'd0, e.pred});
            chk("d_redirect",    {31'd0, d_redirect},   {31'd0, e.d_redir});
            chk("d_redirect_pc", d_redirect_pc,         e.d_rpc);
            chk("e_redirect",    {31'd0, e_redirect},   {31'd0, e.e_redir});
            chk("flush_f",       {31'd0, flush_f},      {31'd0, e.flush});
            chk("e_redirect_pc", e_redirect_pc,         e.e_rpc);
            chk("br_count",      br_count,              e.br);
            chk("miss_count",    miss_count,            e.miss);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   localparam logic [31:0] A = 32'h0000_3000;
   localparam logic [31:0] T = 32'h0000_3400;

   initial begin
      model_reset();
      // Reset with a branch sitting in D.
      repeat (2) step(0, 0, 1, 1, A, T, 0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 1, A, T, 0, 0, 0, 0, 0, 0);
      // Two taken resolves predicted not-taken; second one coincides with a D prediction.
      repeat (2) step(1, 0, 1, 1, A, T, 1, 1, A, T, 0, 1);
      step(1, 0, 1, 1, A, T, 0, 0, 0, 0, 0, 0);
      // Strongly taken entry resolved not-taken: redirect to pc+8.
      step(1, 0, 1, 1, A, T, 1, 1, A, T, 1, 0);
      step(1, 0, 1, 1, A, T, 0, 0, 0, 0, 0, 0);
      // Saturation both ways, with same-index read/write every cycle.
      repeat (5) step(1, 0, 1, 1, A, T, 1, 1, A, T, 1, 1);
      step(1, 0, 1, 1, A, T, 0, 0, 0, 0, 0, 0);
      repeat (5) step(1, 0, 1, 1, A, T, 1, 1, A, T, 0, 0);
      step(1, 0, 1, 1, A, T, 0, 0, 0, 0, 0, 0);
      // Train taken, then a stalled D prediction.
      repeat (3) step(1, 0, 0, 0, 0, 0, 1, 1, A, T, 1, 1);
      step(1, 1, 1, 1, A, T, 0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 1, A, T, 0, 0, 0, 0, 0, 0);
      // Bubble in E flagged as branch: ignored.
      repeat (3) step(1, 0, 1, 1, A, T, 0, 1, A, T, 1, 0);
      // Aliasing PC (same index bits) and an unconditional jump training.
      step(1, 0, 1, 1, A + 32'h100, T, 1, 1, A + 32'h1000, T, 1, 1);
      // Mid-run reset pulse, then prediction starts from the initial state.
      step(0, 0, 1, 1, A, T, 1, 1, A, T, 0, 1);
      step(1, 0, 1, 1, A, T, 0, 0, 0, 0, 0, 0);
      // Random traffic over a handful of indices with random upper PC bits.
      for (int n = 0; n < 600; n++) begin
         logic [31:0] dp, ep;
         dp = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 7) << 2);
         ep = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 7) << 2);
         step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0),
              $urandom_range(0, 1), ($urandom_range(0, 3) != 0), dp, $urandom,
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ep, $urandom,
              $urandom_range(0, 1), $urandom_range(0, 1));
      end
      @(negedge clk);
      #4;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
